// File: rtl/ctrl_pipe_regs.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) with bubble/freeze and retire counter.
// Optional ILLEGAL_OP_TRAP_EN: unsupported opcodes become bubbles and set a sticky illegal_flag.
module ctrl_pipe_regs #(
   parameter int unsigned REGADDR_W    = 5,
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_d,
   input  logic [5:0]              op_d,
   input  logic                    regwrite_d,
   input  logic                    regdst_d,
   input  logic                    alusrc_d,
   input  logic                    branch_d,
   input  logic                    memwrite_d,
   input  logic                    memtoreg_d,
   input  logic                    jump_d,
   input  logic [1:0]              aluop_d,
   input  logic [REGADDR_W-1:0]    rt_d,
   input  logic [REGADDR_W-1:0]    rd_d,
   input  logic                    flush_e,
   input  logic                    hold,
   output logic                    valid_e,
   output logic                    regwrite_e,
   output logic                    alusrc_e,
   output logic                    branch_e,
   output logic                    memwrite_e,
   output logic                    memtoreg_e,
   output logic [1:0]              aluop_e,
   output logic [REGADDR_W-1:0]    writereg_e,
   output logic                    valid_m,
   output logic                    regwrite_m,
   output logic                    memwrite_m,
   output logic                    memtoreg_m,
   output logic [REGADDR_W-1:0]    writereg_m,
   output logic                    valid_w,
   output logic                    regwrite_w,
   output logic                    memtoreg_w,
   output logic [REGADDR_W-1:0]    writereg_w,
   output logic [RETIRE_CNT_W-1:0] retired,
   output logic                    illegal_flag
);

   logic                 op_ok;
   logic                 capture;
   logic                 regdst_e;
   logic [REGADDR_W-1:0] rt_e;
   logic [REGADDR_W-1:0] rd_e;

`ifdef ILLEGAL_OP_TRAP_EN
   logic trap;

   always_comb begin
      case (op_d)
         6'b000000, 6'b100011, 6'b101011,
         6'b000100, 6'b001000, 6'b000010: op_ok = 1'b1;
         default:                         op_ok = 1'b0;
      endcase
   end

   assign trap = valid_d & ~flush_e & ~op_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_flag <= 1'b0;
      end else if (!hold && trap) begin
         illegal_flag <= 1'b1;
      end
   end
`else
   logic unused_op;

   assign op_ok        = 1'b1;
   assign unused_op    = ^op_d;
   assign illegal_flag = 1'b0;
`endif

   // flush wins over a valid decode word
   assign capture = valid_d & ~flush_e & op_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_e    <= 1'b0;
         regwrite_e <= 1'b0;
         regdst_e   <= 1'b0;
         alusrc_e   <= 1'b0;
         branch_e   <= 1'b0;
         memwrite_e <= 1'b0;
         memtoreg_e <= 1'b0;
         aluop_e    <= 2'b00;
         rt_e       <= '0;
         rd_e       <= '0;
      end else if (!hold) begin
         if (capture) begin
            valid_e    <= 1'b1;
            regwrite_e <= regwrite_d & ~jump_d;
            regdst_e   <= regdst_d;
            alusrc_e   <= alusrc_d;
            branch_e   <= branch_d;
            memwrite_e <= memwrite_d;
            memtoreg_e <= memtoreg_d;
            aluop_e    <= aluop_d;
            rt_e       <= rt_d;
            rd_e       <= rd_d;
         end else begin
            valid_e    <= 1'b0;
            regwrite_e <= 1'b0;
            regdst_e   <= 1'b0;
            alusrc_e   <= 1'b0;
            branch_e   <= 1'b0;
            memwrite_e <= 1'b0;
            memtoreg_e <= 1'b0;
            aluop_e    <= 2'b00;
            rt_e       <= '0;
            rd_e       <= '0;
         end
      end
   end

   assign writereg_e = !valid_e ? '0 : (regdst_e ? rd_e : rt_e);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_m    <= 1'b0;
         regwrite_m <= 1'b0;
         memwrite_m <= 1'b0;
         memtoreg_m <= 1'b0;
         writereg_m <= '0;
         valid_w    <= 1'b0;
         regwrite_w <= 1'b0;
         memtoreg_w <= 1'b0;
         writereg_w <= '0;
         retired    <= '0;
      end else if (!hold) begin
         valid_m    <= valid_e;
         regwrite_m <= regwrite_e;
         memwrite_m <= memwrite_e;
         memtoreg_m <= memtoreg_e;
         writereg_m <= writereg_e;
         valid_w    <= valid_m;
         regwrite_w <= regwrite_m;
         memtoreg_w <= memtoreg_m;
         writereg_w <= writereg_m;
         retired    <= retired + {{(RETIRE_CNT_W-1){1'b0}}, valid_w};
      end
   end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: directed steps plus random traffic vs. a stage-list model.
module tb_ctrl_pipe_regs;

   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;  // narrow counter so wrap is reachable

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_d;
   logic [5:0]    op_d;
   logic          regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d;
   logic [1:0]    aluop_d;
   logic [RW-1:0] rt_d, rd_d;
   logic          flush_e, hold;
   logic          valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e;
   logic [1:0]    aluop_e;
   logic [RW-1:0] writereg_e;
   logic          valid_m, regwrite_m, memwrite_m, memtoreg_m;
   logic [RW-1:0] writereg_m;
   logic          valid_w, regwrite_w, memtoreg_w;
   logic [RW-1:0] writereg_w;
   logic [CW-1:0] retired;
   logic          illegal_flag;

   always #5 clk = ~clk;

   ctrl_pipe_regs #(.REGADDR_W(RW), .RETIRE_CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d),
      .regwrite_d(regwrite_d), .regdst_d(regdst_d), .alusrc_d(alusrc_d),
      .branch_d(branch_d), .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d),
      .jump_d(jump_d), .aluop_d(aluop_d), .rt_d(rt_d), .rd_d(rd_d),
      .flush_e(flush_e), .hold(hold),
      .valid_e(valid_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e),
      .branch_e(branch_e), .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e),
      .aluop_e(aluop_e), .writereg_e(writereg_e),
      .valid_m(valid_m), .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
      .memtoreg_m(memtoreg_m), .writereg_m(writereg_m),
      .valid_w(valid_w), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
      .writereg_w(writereg_w), .retired(retired), .illegal_flag(illegal_flag)
   );

   // One in-flight instruction as the spec describes it; an all-zero record is a bubble.
   typedef struct packed {
      logic          v;
      logic          rw;
      logic          asrc;
      logic          br;
      logic          mw;
      logic          m2r;
      logic [1:0]    aop;
      logic [RW-1:0] wr;
   } ins_t;

   ins_t        stage [3];  // 0=EX, 1=MEM, 2=WB
   int unsigned m_retired;
   logic        m_illegal;
   int          total = 0;
   int          bad = 0;

   localparam logic [6:0] CtlLw   = 7'b1010010;  // {rw,rdst,asrc,br,mw,m2r,j}
   localparam logic [6:0] CtlR    = 7'b1100000;
   localparam logic [6:0] CtlSw   = 7'b0010100;
   localparam logic [6:0] CtlAddi = 7'b1010000;
   localparam logic [6:0] CtlJ    = 7'b0000001;
   localparam logic [6:0] CtlBeq  = 7'b0001000;

   function automatic logic op_legal(input logic [5:0] op);
`ifdef ILLEGAL_OP_TRAP_EN
      logic [5:0] ok [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
      foreach (ok[i]) if (op == ok[i]) return 1'b1;
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step();
      ins_t nw;
      if (reset) begin
         foreach (stage[i]) stage[i] = '0;
         m_retired = 0;
         m_illegal = 1'b0;
      end else if (!hold) begin
         nw = '0;
         if (valid_d && !flush_e && op_legal(op_d)) begin
            nw.v    = 1'b1;
            nw.rw   = regwrite_d && !jump_d;
            nw.asrc = alusrc_d;
            nw.br   = branch_d;
            nw.mw   = memwrite_d;
            nw.m2r  = memtoreg_d;
            nw.aop  = aluop_d;
            nw.wr   = regdst_d ? rd_d : rt_d;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         if (valid_d && !flush_e && !op_legal(op_d)) m_illegal = 1'b1;
`endif
         if (stage[2].v) m_retired = (m_retired + 1) % (1 << CW);
         stage[2] = stage[1];
         stage[1] = stage[0];
         stage[0] = nw;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("valid_e",      32'(valid_e),      32'(stage[0].v));
      chk("regwrite_e",   32'(regwrite_e),   32'(stage[0].rw));
      chk("alusrc_e",     32'(alusrc_e),     32'(stage[0].asrc));
      chk("branch_e",     32'(branch_e),     32'(stage[0].br));
      chk("memwrite_e",   32'(memwrite_e),   32'(stage[0].mw));
      chk("memtoreg_e",   32'(memtoreg_e),   32'(stage[0].m2r));
      chk("aluop_e",      32'(aluop_e),      32'(stage[0].aop));
      chk("writereg_e",   32'(writereg_e),   32'(stage[0].wr));
      chk("valid_m",      32'(valid_m),      32'(stage[1].v));
      chk("regwrite_m",   32'(regwrite_m),   32'(stage[1].rw));
      chk("memwrite_m",   32'(memwrite_m),   32'(stage[1].mw));
      chk("memtoreg_m",   32'(memtoreg_m),   32'(stage[1].m2r));
      chk("writereg_m",   32'(writereg_m),   32'(stage[1].wr));
      chk("valid_w",      32'(valid_w),      32'(stage[2].v));
      chk("regwrite_w",   32'(regwrite_w),   32'(stage[2].rw));
      chk("memtoreg_w",   32'(memtoreg_w),   32'(stage[2].m2r));
      chk("writereg_w",   32'(writereg_w),   32'(stage[2].wr));
      chk("retired",      32'(retired),      m_retired);
      chk("illegal_flag", 32'(illegal_flag), 32'(m_illegal));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drv(input logic v, input logic [5:0] op, input logic [6:0] ctl,
                      input logic [1:0] aop, input logic [RW-1:0] rt, input logic [RW-1:0] rd);
      valid_d = v;
      op_d    = op;
      {regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d} = ctl;
      aluop_d = aop;
      rt_d    = rt;
      rd_d    = rd;
   endtask

   task automatic idle();
      drv(1'b0, 6'd0, 7'd0, 2'b00, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1; hold = 1'b0; flush_e = 1'b0;
      idle();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
      foreach (stage[i]) stage[i] = '0;
      m_retired = 0;
      m_illegal = 1'b0;
      reset = 1'b1; hold = 1'b0; flush_e = 1'b0;
      idle();

      // reset, then 10 idle cycles
      do_reset();
      chk("rst_valid_w", 32'(valid_w), 32'd0);
      repeat (10) tick();
      chk("idle_retired", 32'(retired), 32'd0);

      // LW r8
      drv(1'b1, 6'b100011, CtlLw, 2'b00, 5'd8, 5'd3);
      tick();
      chk("lw_writereg_e", 32'(writereg_e), 32'd8);
      idle();
      tick();
      chk("lw_writereg_m", 32'(writereg_m), 32'd8);
      chk("lw_memtoreg_m", 32'(memtoreg_m), 32'd1);
      tick();
      chk("lw_regwrite_w", 32'(regwrite_w), 32'd1);
      chk("lw_writereg_w", 32'(writereg_w), 32'd8);
      tick();
      chk("lw_retired", 32'(retired), 32'd1);

      // R-type rd=9, then a flushed SW
      drv(1'b1, 6'b000000, CtlR, 2'b10, 5'd4, 5'd9);
      tick();
      chk("r_writereg_e", 32'(writereg_e), 32'd9);
      chk("r_aluop_e", 32'(aluop_e), 32'd2);
      drv(1'b1, 6'b101011, CtlSw, 2'b00, 5'd5, 5'd0);
      flush_e = 1'b1;
      tick();
      chk("sw_flush_valid_e", 32'(valid_e), 32'd0);
      flush_e = 1'b0;
      idle();
      repeat (3) begin
         tick();
         chk("sw_flush_memwrite_m", 32'(memwrite_m), 32'd0);
      end

      // Jump enters EX valid with regwrite=0, even if decoder claims a write
      drv(1'b1, 6'b000010, CtlJ | 7'b1000000, 2'b00, 5'd1, 5'd2);
      tick();
      chk("j_valid_e", 32'(valid_e), 32'd1);
      chk("j_regwrite_e", 32'(regwrite_e), 32'd0);

      // 4 ADDIs with a 3-cycle hold mid-stream
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 6'b001000, CtlAddi, 2'b00, RW'(i + 1), 5'd0);
         if (i == 2) begin
            hold = 1'b1;
            repeat (3) begin
               tick();
               chk("hold_writereg_e", 32'(writereg_e), 32'd2);
               chk("hold_retired", 32'(retired), 32'd0);
            end
            hold = 1'b0;
         end
         tick();
      end
      idle();
      repeat (4) tick();
      chk("addi_retired", 32'(retired), 32'd4);

      // flush during hold is ignored
      drv(1'b1, 6'b001000, CtlAddi, 2'b00, 5'd7, 5'd0);
      tick();
      drv(1'b1, 6'b000100, CtlBeq, 2'b01, 5'd3, 5'd0);
      hold = 1'b1; flush_e = 1'b1;
      tick();
      hold = 1'b0; flush_e = 1'b0;
      idle();
      chk("hfl_valid_e", 32'(valid_e), 32'd1);
      chk("hfl_writereg_e", 32'(writereg_e), 32'd7);
      tick();
      chk("hfl_writereg_m", 32'(writereg_m), 32'd7);

`ifdef ILLEGAL_OP_TRAP_EN
      do_reset();
      drv(1'b1, 6'b111111, 7'bxxxxxxx, 2'bxx, 5'bxxxxx, 5'bxxxxx);
      tick();
      chk("ill_valid_e", 32'(valid_e), 32'd0);
      chk("ill_flag", 32'(illegal_flag), 32'd1);
      idle();
      repeat (5) tick();
      chk("ill_flag_sticky", 32'(illegal_flag), 32'd1);
      do_reset();
      chk("ill_flag_reset", 32'(illegal_flag), 32'd0);
`endif

      // counter wraps modulo 2^CW
      do_reset();
      for (int i = 0; i < (1 << CW) + 1; i++) begin
         drv(1'b1, 6'b001000, CtlAddi, 2'b00, RW'(i), 5'd0);
         tick();
      end
      idle();
      repeat (3) tick();
      chk("wrap_retired", 32'(retired), 32'd1);

      // random traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [5:0] op;
         op = ops[$urandom_range(5)];
`ifdef ILLEGAL_OP_TRAP_EN
         if ($urandom_range(7) == 0) op = 6'($urandom);
`endif
         drv($urandom_range(3) != 0, op, 7'($urandom), 2'($urandom), RW'($urandom), RW'($urandom));
         flush_e = ($urandom_range(5) == 0);
         hold    = ($urandom_range(4) == 0);
         reset   = ($urandom_range(63) == 0);
         tick();
      end
      reset = 1'b0; hold = 1'b0; flush_e = 1'b0;
      idle();
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
Control-path pipeline registers for the 5-stage MIPS core. Captures the decode-stage control word from the main decoder, plus the rt/rd register fields, and carries them through the ID/EX, EX/MEM and MEM/WB boundaries. Each field is dropped once its stage has consumed it. The block applies hazard-unit bubbles and global freezes, resolves the write-register address in EX, and counts retired instructions.

Parameters:
REGADDR_W, 5, register-file address width
RETIRE_CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
valid_d  in  1  decode stage holds a real instruction
op_d  in  6  opcode of decode-stage instruction (used only by the optional feature)
regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, jump_d  in  1 each  decoder controls
aluop_d  in  2  decoder ALU op class
rt_d, rd_d  in  REGADDR_W  instruction register fields
flush_e  in  1  load-use or taken-branch bubble request into EX
hold  in  1  global freeze (memory wait)
valid_e, regwrite_e, alusrc_e, branch_e, memwrite_e, memtoreg_e  out  1 each  EX-stage controls
aluop_e  out  2  EX ALU op class
writereg_e  out  REGADDR_W  EX destination register
valid_m, regwrite_m, memwrite_m, memtoreg_m  out  1 each  MEM-stage controls
writereg_m  out  REGADDR_W  MEM destination register
valid_w, regwrite_w, memtoreg_w  out  1 each  WB-stage controls
writereg_w  out  REGADDR_W  WB destination register
retired  out  RETIRE_CNT_W  count of instructions leaving WB
illegal_flag  out  1  sticky illegal-opcode flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: every output register is 0, including the valid bits, controls, writereg and retired. The whole pipe holds bubbles. Reset overrides hold and flush, including mid-operation.
- Bubble definition: valid=0 and all controls=0, with writereg=0 and aluop=00.
- Each stage has 1-cycle latency. A decode word appears on the *_e outputs the cycle after capture, on *_m one cycle later, and on *_w one cycle after that.
- The block registers rt_d and rd_d into ID/EX. writereg_e is computed combinationally in EX: rd when regdst is set, otherwise rt. writereg_e is forced to 0 when valid_e=0. The registered writereg value is passed on to MEM/WB.
- Capture into ID/EX:
  - hold=1: the stage keeps its contents.
  - hold=0 and flush_e=1: the stage takes a bubble.
  - hold=0 and valid_d=0: the stage takes a bubble.
  - Otherwise: the stage captures the decode word.
- hold freezes all three stages and the counter. hold has priority over flush_e, so a flush_e asserted during hold is ignored; the hazard unit must reassert it after hold drops.
- jump_d is consumed in decode. It is not pipelined; a jump enters EX as a valid instruction with regwrite=0.
- branch is carried to EX only. alusrc and aluop are carried to EX only. memwrite is carried to MEM only.
- EX to MEM and MEM to WB transfer every non-hold cycle, with no internal stalls.
- retired increments by 1 on each non-hold cycle where valid_w=1. It wraps modulo 2^RETIRE_CNT_W with no saturation.
- Simultaneous flush_e and valid_d: the flush wins and the instruction is discarded.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: op_d is checked against the supported set {000000, 100011, 101011, 000100, 001000, 000010}. Any other opcode with valid_d=1, hold=0 and flush_e=0 enters ID/EX as a bubble, whatever the control inputs (which may be X). It also sets illegal_flag, which stays set until reset.
- Undefined: op_d is ignored, the controls pass through unchanged, and illegal_flag is constant 0.

Test Plan:
- Reset then idle: all outputs are 0, and retired=0 after 10 cycles with valid_d=0.
- LW (regwrite=1, alusrc=1, memtoreg=1, rt=8, rd=3): writereg_e=8 at cycle+1, writereg_m=8 and memtoreg_m=1 at +2, regwrite_w=1 and writereg_w=8 at +3, and retired increments by 1.
- R-type (regdst=1, aluop=10, rt=4, rd=9): writereg_e=9 and aluop_e=10. Then flush_e on the next SW: valid_e=0 and memwrite_m never asserts.
- Back-to-back ADDI ×4, with hold asserted for 3 cycles mid-stream: all stage outputs are frozen, retired does not increment during hold, and the final retired count is 4.
- flush_e asserted during hold: ignored, and the EX contents are unchanged when hold drops.
- With ILLEGAL_OP_TRAP_EN: op_d=111111, valid_d=1 gives valid_e=0 and illegal_flag=1, and the flag persists until reset. Preload retired to 2^RETIRE_CNT_W-1, retire one instruction, and check it wraps to 0.
